mem_arbiter: RTL

Single-port memory arbiter placed between the shared RAM controller port and its three masters: CPU Wishbone accesses, video refresh reads and disk-copy DMA. It grants the port to one requester at a time with fixed priority (video > DMA > CPU) plus a CPU anti-starvation guard. It sequences each access through a request/ready handshake and returns read data with a one-cycle ack. A watchdog aborts any access the memory never completes.

---
 rtl/mem_arbiter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for video, DMA and CPU masters.
// Fixed priority video > DMA > CPU, with a CPU anti-starvation guard and a BUSY watchdog.
module mem_arbiter #(
  parameter int AW      = 25,
  parameter int STARVE  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          cpu_cyc_i,
  input  logic          cpu_stb_i,
  input  logic          cpu_we_i,
  input  logic [1:0]    cpu_sel_i,
  input  logic [AW-1:0] cpu_adr_i,
  input  logic [15:0]   cpu_dat_i,
  output logic [15:0]   cpu_dat_o,
  output logic          cpu_ack_o,
  input  logic          vid_req_i,
  input  logic [AW-1:0] vid_adr_i,
  output logic [15:0]   vid_dat_o,
  output logic          vid_ack_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_adr_i,
  input  logic [15:0]   dma_dat_i,
  output logic [15:0]   dma_dat_o,
  output logic          dma_ack_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [1:0]    mem_sel_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [15:0]   mem_dat_o,
  input  logic [15:0]   mem_dat_i,
  input  logic          mem_rdy_i,
  output logic [1:0]    grant_o,
  output logic          err_o
);

  localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_VID  = 2'b01;
  localparam logic [1:0] G_DMA  = 2'b10;
  localparam logic [1:0] G_CPU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [SW-1:0] starve_r, starve_s;
  logic [TW-1:0] tmo_r, tmo_s;
  logic          mem_req_r, mem_req_s;
  logic          mem_we_r, mem_we_s;
  logic [1:0]    mem_sel_r, mem_sel_s;
  logic [AW-1:0] mem_adr_r, mem_adr_s;
  logic [15:0]   mem_dat_r, mem_dat_s;
  logic [15:0]   rd_dat_r, rd_dat_s;
  logic [1:0]    grant_r, grant_s;
  logic          cpu_ack_r, cpu_ack_s;
  logic          vid_ack_r, vid_ack_s;
  logic          dma_ack_r, dma_ack_s;
  logic          err_r, err_s;
  logic          cpu_pend_s;
  logic [1:0]    win_s;

  assign cpu_pend_s = cpu_cyc_i & cpu_stb_i;

  // Next-state and next-register computation for arbitration, handshake and watchdog.
  always_comb begin
    state_s   = state_r;
    starve_s  = starve_r;
    tmo_s     = tmo_r;
    mem_req_s = mem_req_r;
    mem_we_s  = mem_we_r;
    mem_sel_s = mem_sel_r;
    mem_adr_s = mem_adr_r;
    mem_dat_s = mem_dat_r;
    rd_dat_s  = rd_dat_r;
    grant_s   = grant_r;
    cpu_ack_s = 1'b0;
    vid_ack_s = 1'b0;
    dma_ack_s = 1'b0;
    err_s     = 1'b0;
    win_s     = G_NONE;
    case (state_r)
      ST_IDLE: begin
        if (cpu_pend_s && (starve_r == STARVE_MAX)) begin
          win_s = G_CPU;
        end else if (vid_req_i) begin
          win_s = G_VID;
        end else if (dma_req_i) begin
          win_s = G_DMA;
        end else if (cpu_pend_s) begin
          win_s = G_CPU;
        end else begin
          win_s = G_NONE;
        end
        case (win_s)
          G_VID: begin
            mem_adr_s = vid_adr_i;
            mem_we_s  = 1'b0;
            mem_sel_s = 2'b11;
            mem_dat_s = 16'h0000;
          end
          G_DMA: begin
            mem_adr_s = dma_adr_i;
            mem_we_s  = dma_we_i;
            mem_sel_s = 2'b11;
            mem_dat_s = dma_dat_i;
          end
          G_CPU: begin
            mem_adr_s = cpu_adr_i;
            mem_we_s  = cpu_we_i;
            mem_sel_s = cpu_sel_i;
            mem_dat_s = cpu_dat_i;
          end
          default: begin
            mem_adr_s = mem_adr_r;
          end
        endcase
        if (win_s != G_NONE) begin
          mem_req_s = 1'b1;
          grant_s   = win_s;
          tmo_s     = {TW{1'b0}};
          state_s   = ST_BUSY;
          // Only a CPU that is actually waiting accumulates starvation credit.
          if ((win_s != G_CPU) && cpu_pend_s) begin
            starve_s = (starve_r == STARVE_MAX) ? starve_r : starve_r + SW'(1);
          end else begin
            starve_s = {SW{1'b0}};
          end
        end else begin
          grant_s = G_NONE;
        end
      end
      ST_BUSY: begin
        if (mem_rdy_i) begin
          mem_req_s = 1'b0;
          rd_dat_s  = mem_dat_i;
          vid_ack_s = (grant_r == G_VID);
          dma_ack_s = (grant_r == G_DMA);
          cpu_ack_s = (grant_r == G_CPU);
          state_s   = ST_DONE;
        end else if (tmo_r == TMO_LAST) begin
          mem_req_s = 1'b0;
          rd_dat_s  = 16'hFFFF;
          vid_ack_s = (grant_r == G_VID);
          dma_ack_s = (grant_r == G_DMA);
          cpu_ack_s = (grant_r == G_CPU);
          err_s     = 1'b1;
          state_s   = ST_DONE;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      ST_DONE: begin
        grant_s = G_NONE;
        tmo_s   = {TW{1'b0}};
        state_s = ST_IDLE;
      end
      default: begin
        mem_req_s = 1'b0;
        grant_s   = G_NONE;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset drops any in-flight access silently.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r   <= ST_IDLE;
      starve_r  <= {SW{1'b0}};
      tmo_r     <= {TW{1'b0}};
      mem_req_r <= 1'b0;
      mem_we_r  <= 1'b0;
      mem_sel_r <= 2'b00;
      mem_adr_r <= {AW{1'b0}};
      mem_dat_r <= 16'h0000;
      rd_dat_r  <= 16'h0000;
      grant_r   <= G_NONE;
      cpu_ack_r <= 1'b0;
      vid_ack_r <= 1'b0;
      dma_ack_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      starve_r  <= starve_s;
      tmo_r     <= tmo_s;
      mem_req_r <= mem_req_s;
      mem_we_r  <= mem_we_s;
      mem_sel_r <= mem_sel_s;
      mem_adr_r <= mem_adr_s;
      mem_dat_r <= mem_dat_s;
      rd_dat_r  <= rd_dat_s;
      grant_r   <= grant_s;
      cpu_ack_r <= cpu_ack_s;
      vid_ack_r <= vid_ack_s;
      dma_ack_r <= dma_ack_s;
      err_r     <= err_s;
    end
  end

  assign mem_req_o = mem_req_r;
  assign mem_we_o  = mem_we_r;
  assign mem_sel_o = mem_sel_r;
  assign mem_adr_o = mem_adr_r;
  assign mem_dat_o = mem_dat_r;
  assign cpu_dat_o = rd_dat_r;
  assign vid_dat_o = rd_dat_r;
  assign dma_dat_o = rd_dat_r;
  assign cpu_ack_o = cpu_ack_r;
  assign vid_ack_o = vid_ack_r;
  assign dma_ack_o = dma_ack_r;
  assign grant_o   = grant_r;
  assign err_o     = err_r;

endmodule
